// File: rtl/write_through_reg_file.sv
// Register file with combinational reads, per-entry pending (scoreboard) bits and optional
// same-cycle write-through enabled by the WRITE_THROUGH_REG_FILE_BYPASS_EN macro.
module write_through_reg_file #(
    parameter int                   DATA_SIZE     = 32,
    parameter int                   ADDR_SIZE     = 5,
    parameter int                   READ_PORTS    = 2,
    parameter logic [DATA_SIZE-1:0] INITIAL_VALUE = '0,
    parameter int                   ZERO_REG      = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             we,
    input  logic [ADDR_SIZE-1:0]             waddr,
    input  logic [DATA_SIZE-1:0]             wdata,
    input  logic                             issue_en,
    input  logic [ADDR_SIZE-1:0]             issue_addr,
    input  logic [READ_PORTS*ADDR_SIZE-1:0]  raddr,
    output logic [READ_PORTS*DATA_SIZE-1:0]  rdata,
    output logic [READ_PORTS-1:0]            rpending
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [DEPTH-1:0]     pend;
    logic [DEPTH-1:0]     pend_next;
    logic                 write_ok;

    // Entry 0 is hard-wired when ZERO_REG is set, so its storage is never touched.
    assign write_ok = we && !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= INITIAL_VALUE;
            end
        end else if (write_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Set after clear: a new producer issued on the same edge as the old one's write wins.
    always_comb begin
        pend_next = pend;
        if (we) begin
            pend_next[waddr] = 1'b0;
        end
        if (issue_en) begin
            pend_next[issue_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pend_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    for (genvar i = 0; i < READ_PORTS; i++) begin : g_read
        logic [ADDR_SIZE-1:0] ra;
        logic                 is_zero;
        logic                 hit;
        logic                 kill;

        assign ra      = raddr[i*ADDR_SIZE +: ADDR_SIZE];
        assign is_zero = (ZERO_REG != 0) && (ra == '0);

`ifdef WRITE_THROUGH_REG_FILE_BYPASS_EN
        // Bypass is suppressed during reset so outputs show only the reset image.
        assign hit  = we && !reset && (waddr == ra);
        assign kill = hit && !(issue_en && (issue_addr == ra));
`else
        assign hit  = 1'b0;
        assign kill = 1'b0;
`endif

        assign rdata[i*DATA_SIZE +: DATA_SIZE] = is_zero ? '0 : (hit ? wdata : mem[ra]);
        assign rpending[i] = !is_zero && !kill && pend[ra];
    end

endmodule

// File: tb/tb_write_through_reg_file.sv
// Directed and randomized checks of write_through_reg_file against an array-based reference model.
module tb_write_through_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NP = 2;
    localparam int DEPTH = 32;
    localparam logic [DW-1:0] INIT = 32'h0000_1234;
`ifdef WRITE_THROUGH_REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic              issue_en;
    logic [AW-1:0]     issue_addr;
    logic [NP*AW-1:0]  raddr;
    logic [NP*DW-1:0]  rdata;
    logic [NP-1:0]     rpending;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_mem [DEPTH];
    bit            model_pend [DEPTH];

    write_through_reg_file #(
        .DATA_SIZE(DW), .ADDR_SIZE(AW), .READ_PORTS(NP),
        .INITIAL_VALUE(INIT), .ZERO_REG(1)
    ) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .raddr(raddr), .rdata(rdata), .rpending(rpending)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int e = 0; e < DEPTH; e++) begin
            model_mem[e]  = INIT;
            model_pend[e] = 1'b0;
        end
    endtask

    // Architectural state changes at an edge where reset is low.
    task automatic model_edge();
        if (we && waddr != 0) model_mem[waddr] = wdata;
        if (we) model_pend[waddr] = 1'b0;
        if (issue_en) model_pend[issue_addr] = 1'b1;
        model_pend[0] = 1'b0;
    endtask

    task automatic check_ports(input string tag);
        logic [AW-1:0] a;
        logic [DW-1:0] exp_d;
        logic          exp_p;
        bit            bypassed;
        for (int p = 0; p < NP; p++) begin
            a = raddr[p*AW +: AW];
            bypassed = BYPASS && !reset && we && (waddr == a);
            if (a == 0) begin
                exp_d = '0;
                exp_p = 1'b0;
            end else begin
                exp_d = bypassed ? wdata : model_mem[a];
                exp_p = (bypassed && !(issue_en && issue_addr == a)) ? 1'b0 : model_pend[a];
            end
            checks++;
            assert (rdata[p*DW +: DW] === exp_d) else begin
                errors++;
                $error("FAIL %s rdata[%0d] addr=%0d got=%h exp=%h", tag, p, a, rdata[p*DW +: DW], exp_d);
            end
            checks++;
            assert (rpending[p] === exp_p) else begin
                errors++;
                $error("FAIL %s rpending[%0d] addr=%0d got=%b exp=%b", tag, p, a, rpending[p], exp_p);
            end
        end
    endtask

    // Inputs are set at the falling edge; outputs checked 1ns later, model advanced at the rising edge.
    task automatic step(input string tag);
        if (reset) model_reset();
        #1;
        check_ports(tag);
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        we = 1'b0; issue_en = 1'b0;
        waddr = '0; wdata = '0; issue_addr = '0;
    endtask

    task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    initial begin
        reset = 1'b1;
        idle();
        set_raddr(0, 0);
        model_reset();

        // Reset image over every address; writes/issues during reset must be ignored.
        for (int a = 0; a < DEPTH; a++) begin
            we = 1'b1; waddr = AW'(a); wdata = $urandom;
            issue_en = 1'b1; issue_addr = AW'(a);
            set_raddr(AW'(a), AW'(DEPTH - 1 - a));
            step("reset_read");
        end
        idle();
        reset = 1'b0;
        set_raddr(5, 9);
        step("after_reset");

        // Write to entry 5 with same-cycle read.
        we = 1'b1; waddr = 5; wdata = 32'hDEAD_BEEF; set_raddr(5, 5);
        step("wt_write5");
        idle(); set_raddr(5, 6);
        step("wt_after5");

        // Writes to entry 0 are discarded.
        we = 1'b1; waddr = 0; wdata = 32'hFFFF_FFFF; set_raddr(0, 0);
        step("zero_write");
        idle();
        step("zero_after");

        // Issue 7, read pending, write 7 clears it.
        issue_en = 1'b1; issue_addr = 7; set_raddr(1, 7);
        step("issue7");
        idle();
        step("pend7");
        we = 1'b1; waddr = 7; wdata = 32'h0000_0777;
        step("clear7");
        idle();
        step("after7");

        // Issue and write same address: bit stays set, data stored.
        we = 1'b1; waddr = 9; wdata = 32'hCAFE_0009;
        issue_en = 1'b1; issue_addr = 9; set_raddr(9, 9);
        step("issue_write9");
        idle();
        step("after9");

        // Issue to address 0 is ignored.
        issue_en = 1'b1; issue_addr = 0; set_raddr(0, 0);
        step("issue0");
        idle();
        step("after_issue0");

        // Randomized traffic on a narrow address window to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            waddr = AW'($urandom_range(0, 7));
            wdata = $urandom;
            issue_en = 1'($urandom_range(0, 1));
            issue_addr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 7));
            set_raddr(($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) == 0) ? issue_addr : AW'($urandom_range(0, 31)));
            step("random");
        end
        idle();

        // Pending bits 3 and 4, write 3, then asynchronous reset between edges.
        issue_en = 1'b1; issue_addr = 3; set_raddr(3, 4);
        step("set3");
        issue_addr = 4;
        step("set4");
        idle(); we = 1'b1; waddr = 3; wdata = 32'h3333_3333;
        step("write3");
        idle();
        step("pend34");
        we = 1'b1; waddr = 3; wdata = 32'hBAD0_0003; issue_en = 1'b1; issue_addr = 4;
        reset = 1'b1;
        step("async_reset");
        idle();
        step("reset_hold");
        reset = 1'b0;
        set_raddr(3, 4);
        step("post_reset34");
        set_raddr(5, 9);
        step("post_reset59");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_through_reg_file.md
WRITE_THROUGH_REG_FILE -- requirements
Module: write_through_reg_file

Interface
REQ-001 Parameter DATA_SIZE, default 32, data width in bits.
REQ-002 Parameter ADDR_SIZE, default 5, address width; depth = 2**ADDR_SIZE entries.
REQ-003 Parameter READ_PORTS, default 2, number of read ports, range 1..4.
REQ-004 Parameter INITIAL_VALUE, default 0, value loaded into every entry on reset.
REQ-005 Parameter ZERO_REG, default 1; when 1, entry 0 reads as 0, is never written and is never pending.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 we  input  1  write enable.
REQ-009 waddr  input  ADDR_SIZE  write address.
REQ-010 wdata  input  DATA_SIZE  write data.
REQ-011 issue_en  input  1  marks entry issue_addr pending (producer in flight).
REQ-012 issue_addr  input  ADDR_SIZE  entry to mark pending.
REQ-013 raddr  input  READ_PORTS*ADDR_SIZE  packed read addresses, port i at [i*ADDR_SIZE +: ADDR_SIZE].
REQ-014 rdata  output  READ_PORTS*DATA_SIZE  packed read data, port i at [i*DATA_SIZE +: DATA_SIZE].
REQ-015 rpending  output  READ_PORTS  per-port flag: addressed entry still awaits its producer.

Function
REQ-016 Storage SHALL update on rising clk when we=1: entry[waddr] <= wdata; no update when we=0.
REQ-017 Reads SHALL be combinational: rdata[i] = stored entry[raddr[i]], subject to REQ-018 and REQ-019.
REQ-018 Write-through: when we=1 and raddr[i]==waddr, rdata[i] SHALL equal wdata in the same cycle, zero latency.
REQ-019 ZERO_REG=1: raddr[i]==0 SHALL yield rdata[i]=0 regardless of we/waddr; write to waddr=0 SHALL be discarded.
REQ-020 Scoreboard: one pending bit per entry; issue_en=1 sets bit[issue_addr] at next edge; we=1 clears bit[waddr] at next edge.
REQ-021 Simultaneous issue_en and we to the same address SHALL leave the bit set (new producer wins).
REQ-022 rpending[i] SHALL equal bit[raddr[i]], forced 0 when we=1 and waddr==raddr[i] unless issue_en=1 with issue_addr==raddr[i] in the same cycle.
REQ-023 ZERO_REG=1: bit[0] SHALL remain 0; issue to address 0 ignored; rpending for address 0 always 0.
REQ-024 All read ports SHALL be independent; identical addresses on multiple ports SHALL return identical data and pending flags.
REQ-025 No X SHALL propagate from unwritten entries; all entries defined from reset.

Reset
REQ-026 reset=1 SHALL immediately, without clk, set every entry to INITIAL_VALUE and clear every pending bit.
REQ-027 While reset=1, writes and issues SHALL be ignored; rdata reflects INITIAL_VALUE (0 for entry 0 if ZERO_REG) and rpending=0, including write-through path.
REQ-028 Reset asserted mid-operation SHALL discard any same-edge write or issue.

Configuration
REQ-029 Macro WRITE_THROUGH_REG_FILE_BYPASS_EN: defined -> REQ-018 and the clear-forcing of REQ-022 active; undefined -> rdata and rpending reflect stored state only, new value visible from the cycle after the write edge.

Verification
REQ-030 Reset, then read all addresses with INITIAL_VALUE=32'h0000_1234 -> every port returns 32'h1234 except address 0 returns 0; rpending all 0.
REQ-031 we=1, waddr=5, wdata=32'hDEAD_BEEF, raddr0=5 same cycle -> rdata0=32'hDEADBEEF immediately (bypass on); bypass off -> old value this cycle, DEADBEEF next cycle.
REQ-032 we=1, waddr=0, wdata=32'hFFFF_FFFF, raddr0=raddr1=0 -> both ports read 0 this and following cycle.
REQ-033 issue_en addr 7; next cycle raddr1=7 -> rpending[1]=1; cycle with we addr 7 -> rpending[1]=0 (bypass on), bit cleared afterwards.
REQ-034 Same cycle issue_en and we both addr 9 -> bit[9]=1 after edge, entry 9 holds written data.
REQ-035 Set bits 3 and 4, write entry 3, assert reset between edges -> outputs return to reset values without clock edge; entry 3 = INITIAL_VALUE.
